// File: rtl/bolt_launch_ctrl.sv
// bolt_launch_ctrl: fire arbitration, frame cooldown and per-slot fly/retire control for the bolt mover pool.
// Optional feature macro BOLT_LAUNCH_AUTOFIRE_EN: a held fireReq re-arms fire on every cooldown-free frame.
module bolt_launch_ctrl #(
  parameter int unsigned NUM_BOLTS       = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned TOP_LIMIT       = 16,
  parameter int unsigned SCREEN_H        = 480
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic                           fireReq,
  input  logic [NUM_BOLTS*11-1:0]        boltY,
  input  logic [NUM_BOLTS-1:0]           boltHit,
  output logic [NUM_BOLTS-1:0]           shootCmd,
  output logic                           launchPulse,
  output logic [$clog2(NUM_BOLTS+1)-1:0] activeCount,
  output logic                           cooldownBusy
);

  localparam int unsigned Y_W   = 11;
  localparam int unsigned CNT_W = $clog2(NUM_BOLTS + 1);
  localparam int unsigned CD_W  = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLY    = 2'd1,
    S_RETIRE = 2'd2
  } slot_state_e;

  slot_state_e          state_q [NUM_BOLTS];
  slot_state_e          state_d [NUM_BOLTS];
  logic                 fire_q;
  logic                 pending_q;
  logic                 pending_d;
  logic [CD_W-1:0]      cd_q;
  logic [CD_W-1:0]      cd_d;
  logic [NUM_BOLTS-1:0] grant;
  logic [NUM_BOLTS-1:0] shoot_d;
  logic [CNT_W-1:0]     fly_cnt;
  logic                 fire_edge;
  logic                 arm;
  logic                 any_idle;
  logic                 launch;

  // Unsigned compare also catches a mover that wrapped past the top into large Y values.
  function automatic logic out_of_bounds(input logic [Y_W-1:0] y);
    return (y <= Y_W'(TOP_LIMIT)) || (y >= Y_W'(SCREEN_H));
  endfunction

  // Next-state: fire capture, launch arbitration, cooldown and slot FSMs.
  always_comb begin
    fire_edge = fireReq & ~fire_q;
    grant     = '0;
    any_idle  = 1'b0;
    fly_cnt   = '0;
    for (int i = 0; i < int'(NUM_BOLTS); i++) begin
      if (!any_idle && state_q[i] == S_IDLE) begin
        grant[i] = 1'b1;
        any_idle = 1'b1;
      end
      if (state_q[i] == S_FLY) begin
        fly_cnt = fly_cnt + CNT_W'(1);
      end
    end

`ifdef BOLT_LAUNCH_AUTOFIRE_EN
    arm = pending_q | (fireReq & (cd_q == '0));
`else
    arm = pending_q;
`endif
    launch = startOfFrame & arm & (cd_q == '0) & any_idle;

    // Any frame boundary consumes the request; an edge in that same cycle arms the next frame.
    pending_d = (startOfFrame ? 1'b0 : pending_q) | fire_edge;

    if (launch) begin
      cd_d = CD_W'(COOLDOWN_FRAMES);
    end else if (startOfFrame && cd_q != '0) begin
      cd_d = cd_q - CD_W'(1);
    end else begin
      cd_d = cd_q;
    end

    for (int i = 0; i < int'(NUM_BOLTS); i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (launch && grant[i]) state_d[i] = S_FLY;
        end
        S_FLY: begin
          if (boltHit[i] || out_of_bounds(boltY[Y_W*i +: Y_W])) state_d[i] = S_RETIRE;
        end
        S_RETIRE: state_d[i] = S_IDLE;
        default:  state_d[i] = S_IDLE;
      endcase
      shoot_d[i] = (state_d[i] == S_FLY);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < int'(NUM_BOLTS); i++) begin
        state_q[i] <= S_IDLE;
      end
      fire_q       <= 1'b0;
      pending_q    <= 1'b0;
      cd_q         <= '0;
      shootCmd     <= '0;
      launchPulse  <= 1'b0;
      activeCount  <= '0;
      cooldownBusy <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_BOLTS); i++) begin
        state_q[i] <= state_d[i];
      end
      fire_q       <= fireReq;
      pending_q    <= pending_d;
      cd_q         <= cd_d;
      shootCmd     <= shoot_d;
      launchPulse  <= launch;
      activeCount  <= fly_cnt;
      cooldownBusy <= (cd_d != '0);
    end
  end

endmodule
